axi_outstanding_limiter: RTL and testbench

Sits directly downstream of the standard cache subsystem's AXI master port, between it and the SoC interconnect. Tracks outstanding read and write transactions per ID class (I$, bypass, D$) and stalls new AR/AW requests when a class reaches its limit. Provides a quiesce/drain handshake so the core can stop issuing memory traffic and wait until all responses have returned, for example before fence.t or a power-down. All other channels pass through combinationally.

---
 rtl/ariane_axi.sv | 59 +++++
 rtl/std_cache_pkg.sv | 23 ++
 rtl/axi_outstanding_cnt.sv | 33 +++
 rtl/axi_outstanding_limiter.sv | 137 +++++++++++++
 tb/tb_axi_outstanding_limiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_axi.sv
// rtl/ariane_axi.sv - AXI channel and request/response structs of the cache subsystem master port
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [3:0]           cache;
  } ax_chan_t;

  typedef ax_chan_t aw_chan_t;
  typedef ax_chan_t ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - cache subsystem ID classes, shared ID decode and limiter states
package std_cache_pkg;

  typedef enum logic [1:0] {
    ICACHE = 2'd0,
    BYPASS = 2'd1,
    DCACHE = 2'd2
  } axi_id_class_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    QUIESCED = 2'd2
  } lim_state_e;

  // Also used by the R/B response routing, so both sides always agree on the class.
  function automatic axi_id_class_e axi_id_class(input logic [3:0] id);
    if (id == 4'b1100) return DCACHE;
    else if (id[3:2] == 2'b10) return BYPASS;
    else return ICACHE;
  endfunction

endpackage

// File: rtl/axi_outstanding_cnt.sv
// rtl/axi_outstanding_cnt.sv - saturating up/down outstanding-transaction counter
module axi_outstanding_cnt #(
  parameter int unsigned MaxCount = 4,
  parameter int unsigned CntWidth = $clog2(MaxCount + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_zero,
  output logic o_underflow
);

  localparam logic [CntWidth-1:0] MaxVal = CntWidth'(MaxCount);

  logic [CntWidth-1:0] r_cnt;

  assign o_full      = (r_cnt == MaxVal);
  assign o_zero      = (r_cnt == '0);
  assign o_underflow = i_dec & ~i_inc & o_zero;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc & ~i_dec & ~o_full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec & ~i_inc & ~o_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/axi_outstanding_limiter.sv
// rtl/axi_outstanding_limiter.sv - per-class outstanding AR/AW limiter with quiesce/drain handshake
module axi_outstanding_limiter
  import std_cache_pkg::*;
#(
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         axi_req_t      = ariane_axi::req_t,
  parameter type         axi_rsp_t      = ariane_axi::resp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_resp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_resp_i,
  input  logic     quiesce_i,
  output logic     idle_o,
  output logic     cnt_err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [AxiIdWidth-1:0] w_ar_id, w_aw_id, w_r_id, w_b_id;
  axi_id_class_e         w_ar_class, w_aw_class, w_r_class, w_b_class;
  logic [2:0]            w_ar_sel, w_aw_sel, w_r_sel, w_b_sel;
  logic [2:0]            w_rd_full, w_rd_zero, w_rd_unf, w_rd_inc, w_rd_dec;
  logic [2:0]            w_wr_full, w_wr_zero, w_wr_unf, w_wr_inc, w_wr_dec;
  logic                  w_ar_open, w_aw_open, w_ar_valid, w_aw_valid;
  logic                  w_ar_hs, w_aw_hs, w_r_hs, w_b_hs, w_drained;
  logic                  r_ar_pend, r_aw_pend, r_idle, r_cnt_err;
  lim_state_e            r_state, w_state_next;

  assign w_ar_id = slv_req_i.ar.id;
  assign w_aw_id = slv_req_i.aw.id;
  assign w_r_id  = mst_resp_i.r.id;
  assign w_b_id  = mst_resp_i.b.id;

  assign w_ar_class = axi_id_class(w_ar_id[3:0]);
  assign w_aw_class = axi_id_class(w_aw_id[3:0]);
  assign w_r_class  = axi_id_class(w_r_id[3:0]);
  assign w_b_class  = axi_id_class(w_b_id[3:0]);

  assign w_ar_sel = 3'b001 << w_ar_class;
  assign w_aw_sel = 3'b001 << w_aw_class;
  assign w_r_sel  = 3'b001 << w_r_class;
  assign w_b_sel  = 3'b001 << w_b_class;

  // Pend keeps an already-presented request open even if its class fills or quiesce arrives.
  assign w_ar_open  = ~(|(w_rd_full & w_ar_sel) | (r_state != RUN)) | r_ar_pend;
  assign w_aw_open  = ~(|(w_wr_full & w_aw_sel) | (r_state != RUN)) | r_aw_pend;
  assign w_ar_valid = slv_req_i.ar_valid & w_ar_open & rst_ni;
  assign w_aw_valid = slv_req_i.aw_valid & w_aw_open & rst_ni;

  assign w_ar_hs = w_ar_valid & mst_resp_i.ar_ready;
  assign w_aw_hs = w_aw_valid & mst_resp_i.aw_ready;
  assign w_r_hs  = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign w_b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;

  assign w_rd_inc = {3{w_ar_hs}} & w_ar_sel;
  assign w_rd_dec = {3{w_r_hs}} & w_r_sel;
  assign w_wr_inc = {3{w_aw_hs}} & w_aw_sel;
  assign w_wr_dec = {3{w_b_hs}} & w_b_sel;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = w_ar_valid;
    mst_req_o.aw_valid = w_aw_valid;
  end

  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_open & rst_ni;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_open & rst_ni;
  end

  for (genvar c = 0; c < 3; c++) begin : g_cnt
    axi_outstanding_cnt #(
      .MaxCount(MaxOutstanding),
      .CntWidth(CntWidth)
    ) i_rd_cnt (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_inc      (w_rd_inc[c]),
      .i_dec      (w_rd_dec[c]),
      .o_full     (w_rd_full[c]),
      .o_zero     (w_rd_zero[c]),
      .o_underflow(w_rd_unf[c])
    );
    axi_outstanding_cnt #(
      .MaxCount(MaxOutstanding),
      .CntWidth(CntWidth)
    ) i_wr_cnt (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_inc      (w_wr_inc[c]),
      .i_dec      (w_wr_dec[c]),
      .o_full     (w_wr_full[c]),
      .o_zero     (w_wr_zero[c]),
      .o_underflow(w_wr_unf[c])
    );
  end

  assign w_drained = (&w_rd_zero) & (&w_wr_zero) & ~r_ar_pend & ~r_aw_pend;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:      if (quiesce_i) w_state_next = DRAIN;
      DRAIN: begin
        if (!quiesce_i) w_state_next = RUN;
        else if (w_drained) w_state_next = QUIESCED;
      end
      QUIESCED: if (!quiesce_i) w_state_next = RUN;
      default:  w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= RUN;
      r_ar_pend <= 1'b0;
      r_aw_pend <= 1'b0;
      r_idle    <= 1'b0;
      r_cnt_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ar_pend <= w_ar_valid & ~mst_resp_i.ar_ready;
      r_aw_pend <= w_aw_valid & ~mst_resp_i.aw_ready;
      r_idle    <= (r_state == QUIESCED);
      r_cnt_err <= r_cnt_err | (|w_rd_unf) | (|w_wr_unf);
    end
  end

  assign idle_o    = r_idle;
  assign cnt_err_o = r_cnt_err;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// tb/tb_axi_outstanding_limiter.sv - self-checking bench for axi_outstanding_limiter (MaxOutstanding=2)
module tb_axi_outstanding_limiter;
  import ariane_axi::*;

  logic  clk = 1'b0;
  logic  rst_n;
  req_t  slv_req, mst_req;
  resp_t slv_resp, mst_resp;
  logic  quiesce, idle, cnt_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [35:0] exp_ar_q[$];
  logic [35:0] exp_aw_q[$];

  always #5 clk = ~clk;

  axi_outstanding_limiter #(
    .AxiIdWidth    (4),
    .MaxOutstanding(2),
    .axi_req_t     (req_t),
    .axi_rsp_t     (resp_t)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp),
    .quiesce_i (quiesce),
    .idle_o    (idle),
    .cnt_err_o (cnt_err)
  );

  // Scoreboard: every downstream AR/AW handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (mst_req.ar_valid && mst_resp.ar_ready) begin
      n_checks++;
      if (exp_ar_q.size() == 0)
        $display("FAIL ar_scoreboard: got id=%h addr=%h, expected no AR", mst_req.ar.id, mst_req.ar.addr);
      else if ({mst_req.ar.id, mst_req.ar.addr} !== exp_ar_q[0]) begin
        $display("FAIL ar_scoreboard: got %h expected %h", {mst_req.ar.id, mst_req.ar.addr}, exp_ar_q[0]);
        void'(exp_ar_q.pop_front());
      end else begin
        n_pass++;
        void'(exp_ar_q.pop_front());
      end
    end
    if (mst_req.aw_valid && mst_resp.aw_ready) begin
      n_checks++;
      if (exp_aw_q.size() == 0)
        $display("FAIL aw_scoreboard: got id=%h addr=%h, expected no AW", mst_req.aw.id, mst_req.aw.addr);
      else if ({mst_req.aw.id, mst_req.aw.addr} !== exp_aw_q[0]) begin
        $display("FAIL aw_scoreboard: got %h expected %h", {mst_req.aw.id, mst_req.aw.addr}, exp_aw_q[0]);
        void'(exp_aw_q.pop_front());
      end else begin
        n_pass++;
        void'(exp_aw_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic offer_ar(input logic [3:0] id, input logic [31:0] addr, input bit will_issue);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = id;
    slv_req.ar.addr  = addr;
    if (will_issue) exp_ar_q.push_back({id, addr});
  endtask

  task automatic offer_aw(input logic [3:0] id, input logic [31:0] addr, input bit will_issue);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = id;
    slv_req.aw.addr  = addr;
    if (will_issue) exp_aw_q.push_back({id, addr});
  endtask

  task automatic send_r(input logic [3:0] id, input int n);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = id;
    mst_resp.r.last  = 1'b1;
    repeat (n) step();
    mst_resp.r_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id, input int n);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = id;
    repeat (n) step();
    mst_resp.b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mst_resp.ar_ready = 1'b1;
    mst_resp.aw_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    repeat (3) step();
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL reset_ar_valid: got %b expected 0", mst_req.ar_valid); else n_pass++;
    n_checks++; if (mst_req.aw_valid !== 1'b0) $display("FAIL reset_aw_valid: got %b expected 0", mst_req.aw_valid); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL reset_idle: got %b expected 0", idle); else n_pass++;
    n_checks++; if (cnt_err !== 1'b0) $display("FAIL reset_cnt_err: got %b expected 0", cnt_err); else n_pass++;
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    rst_n = 1'b1;
    step();
    settle();
    n_checks++; if (idle !== 1'b0) $display("FAIL run_idle: got %b expected 0", idle); else n_pass++;
  endtask

  task automatic test_passthrough();
    w_chan_t w_exp;
    r_chan_t r_exp;
    w_exp = '{data: 64'hDEAD_BEEF_0123_4567, strb: 8'hA5, last: 1'b1};
    r_exp = '{id: 4'h5, data: 64'hCAFE_F00D_8899_AABB, resp: 2'b10, last: 1'b0};
    slv_req.w = w_exp;
    slv_req.w_valid = 1'b1;
    mst_resp.w_ready = 1'b1;
    mst_resp.r = r_exp;
    mst_resp.r_valid = 1'b1;
    settle();
    n_checks++; if (mst_req.w !== w_exp) $display("FAIL pass_w: got %h expected %h", mst_req.w, w_exp); else n_pass++;
    n_checks++; if (mst_req.w_valid !== 1'b1) $display("FAIL pass_w_valid: got %b expected 1", mst_req.w_valid); else n_pass++;
    n_checks++; if (slv_resp.w_ready !== 1'b1) $display("FAIL pass_w_ready: got %b expected 1", slv_resp.w_ready); else n_pass++;
    n_checks++; if (slv_resp.r !== r_exp) $display("FAIL pass_r: got %h expected %h", slv_resp.r, r_exp); else n_pass++;
    step();
    slv_req.w_valid = 1'b0;
    mst_resp.w_ready = 1'b0;
    mst_resp.r_valid = 1'b0;
  endtask

  task automatic test_ar_limit();
    mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      offer_ar(4'hC, 32'h100 + i, 1'b1);
      settle();
      n_checks++; if (mst_req.ar_valid !== 1'b1) $display("FAIL dc_ar_pass%0d: got %b expected 1", i, mst_req.ar_valid); else n_pass++;
      step();
    end
    offer_ar(4'hC, 32'h102, 1'b1);
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL dc_ar_block%0d: got %b expected 0", i, mst_req.ar_valid); else n_pass++;
      n_checks++; if (slv_resp.ar_ready !== 1'b0) $display("FAIL dc_ar_ready_block%0d: got %b expected 0", i, slv_resp.ar_ready); else n_pass++;
      step();
    end
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id = 4'hC;
    mst_resp.r.last = 1'b1;
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL dc_ar_no_bypass: got %b expected 0", mst_req.ar_valid); else n_pass++;
    step();
    mst_resp.r_valid = 1'b0;
    settle();
    n_checks++; if (slv_resp.ar_ready !== 1'b1) $display("FAIL dc_ar_freed: got %b expected 1", slv_resp.ar_ready); else n_pass++;
    step();
    slv_req.ar_valid = 1'b0;
    send_r(4'hC, 2);
  endtask

  task automatic test_class_indep();
    mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      offer_ar(4'h0, 32'h200 + i, 1'b1);
      step();
    end
    offer_ar(4'h0, 32'h202, 1'b0);
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL ic_ar_block: got %b expected 0", mst_req.ar_valid); else n_pass++;
    step();
    offer_ar(4'h9, 32'h210, 1'b1);
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b1) $display("FAIL byp_ar_indep: got %b expected 1", mst_req.ar_valid); else n_pass++;
    step();
    slv_req.ar_valid = 1'b0;
    send_r(4'h0, 2);
    send_r(4'h9, 1);
  endtask

  task automatic test_same_cycle_aw_b();
    mst_resp.aw_ready = 1'b1;
    offer_aw(4'hC, 32'h300, 1'b1);
    step();
    offer_aw(4'hC, 32'h301, 1'b1);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id = 4'hC;
    step();
    mst_resp.b_valid = 1'b0;
    offer_aw(4'hC, 32'h302, 1'b1);
    settle();
    n_checks++; if (mst_req.aw_valid !== 1'b1) $display("FAIL aw_b_same_cycle_room: got %b expected 1", mst_req.aw_valid); else n_pass++;
    step();
    offer_aw(4'hC, 32'h303, 1'b0);
    settle();
    n_checks++; if (mst_req.aw_valid !== 1'b0) $display("FAIL aw_b_same_cycle_full: got %b expected 0", mst_req.aw_valid); else n_pass++;
    n_checks++; if (slv_resp.aw_ready !== 1'b0) $display("FAIL aw_ready_full: got %b expected 0", slv_resp.aw_ready); else n_pass++;
    step();
    slv_req.aw_valid = 1'b0;
    send_b(4'hC, 2);
    settle();
    n_checks++; if (cnt_err !== 1'b0) $display("FAIL aw_b_no_err: got %b expected 0", cnt_err); else n_pass++;
  endtask

  task automatic test_quiesce();
    mst_resp.ar_ready = 1'b0;
    offer_ar(4'h0, 32'h400, 1'b1);
    step();
    quiesce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (mst_req.ar_valid !== 1'b1) $display("FAIL q_ar_held%0d: got %b expected 1", i, mst_req.ar_valid); else n_pass++;
      step();
    end
    mst_resp.ar_ready = 1'b1;
    step();
    offer_ar(4'h0, 32'h401, 1'b0);
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL q_no_new_ar: got %b expected 0", mst_req.ar_valid); else n_pass++;
    n_checks++; if (slv_resp.ar_ready !== 1'b0) $display("FAIL q_no_new_ready: got %b expected 0", slv_resp.ar_ready); else n_pass++;
    step();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id = 4'h0;
    mst_resp.r.last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (idle !== 1'b0) $display("FAIL q_idle_early%0d: got %b expected 0", i, idle); else n_pass++;
      step();
      mst_resp.r_valid = 1'b0;
    end
    settle();
    n_checks++; if (idle !== 1'b1) $display("FAIL q_idle_rise: got %b expected 1", idle); else n_pass++;
    quiesce = 1'b0;
    exp_ar_q.push_back({4'h0, 32'h401});
    step();
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b1) $display("FAIL q_gate_reopen: got %b expected 1", mst_req.ar_valid); else n_pass++;
    step();
    slv_req.ar_valid = 1'b0;
    settle();
    n_checks++; if (idle !== 1'b0) $display("FAIL q_idle_fall: got %b expected 0", idle); else n_pass++;
    send_r(4'h0, 1);
  endtask

  task automatic test_underflow();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id = 4'hC;
    settle();
    n_checks++; if (cnt_err !== 1'b0) $display("FAIL unf_before: got %b expected 0", cnt_err); else n_pass++;
    step();
    mst_resp.b_valid = 1'b0;
    settle();
    n_checks++; if (cnt_err !== 1'b1) $display("FAIL unf_set: got %b expected 1", cnt_err); else n_pass++;
    repeat (3) step();
    n_checks++; if (cnt_err !== 1'b1) $display("FAIL unf_sticky: got %b expected 1", cnt_err); else n_pass++;
    rst_n = 1'b0;
    step();
    settle();
    n_checks++; if (cnt_err !== 1'b0) $display("FAIL unf_reset_clear: got %b expected 0", cnt_err); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_outstanding();
    mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      offer_ar(4'hC, 32'h500 + i, 1'b1);
      step();
    end
    offer_ar(4'h0, 32'h510, 1'b0);
    rst_n = 1'b0;
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL rst_mid_ar_valid: got %b expected 0", mst_req.ar_valid); else n_pass++;
    step();
    step();
    slv_req.ar_valid = 1'b0;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      offer_ar(4'hC, 32'h520 + i, 1'b1);
      settle();
      n_checks++; if (mst_req.ar_valid !== 1'b1) $display("FAIL rst_cnt_cleared%0d: got %b expected 1", i, mst_req.ar_valid); else n_pass++;
      step();
    end
    offer_ar(4'hC, 32'h522, 1'b0);
    settle();
    n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL rst_refill_block: got %b expected 0", mst_req.ar_valid); else n_pass++;
    step();
    slv_req.ar_valid = 1'b0;
    send_r(4'hC, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    slv_req  = '0;
    mst_resp = '0;
    quiesce  = 1'b0;
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    test_reset();
    test_passthrough();
    test_ar_limit();
    test_class_indep();
    test_same_cycle_aw_b();
    test_quiesce();
    test_underflow();
    test_reset_outstanding();
    step();
    n_checks++;
    if (exp_ar_q.size() != 0 || exp_aw_q.size() != 0)
      $display("FAIL scoreboard_drained: got ar=%0d aw=%0d left expected 0", exp_ar_q.size(), exp_aw_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
